// File: rtl/popcount_seq.sv
// popcount_seq
// Sequential population counter. A start in IDLE captures an operand
// (inverted when counting zeros) and scans it BITS_PER_CYCLE bits per
// clock. The sum is published on bit_count with a one-cycle done pulse.
// A start accepted at edge N gives a result after edge N+K+1, where
// K = DATA_WIDTH/BITS_PER_CYCLE.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   start        begin a count (only looked at in IDLE)
//   count_zeros  0: count ones, 1: count zeros (sampled with start)
//   data         operand (sampled with start)
//   busy         high from start acceptance until the result is published
//   done         one-cycle pulse: bit_count just updated
//   bit_count    most recent result, held between operations
module popcount_seq #(
  parameter int DATA_WIDTH     = 16,
  parameter int BITS_PER_CYCLE = 4,
  parameter int COUNT_WIDTH    = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   count_zeros,
  input  logic [DATA_WIDTH-1:0]  data,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] bit_count
);

  localparam int K         = DATA_WIDTH / BITS_PER_CYCLE;
  // The index has to be able to hold K itself, the value it reaches after the last scan edge.
  localparam int IDX_WIDTH = $clog2(K + 1);
  localparam logic [IDX_WIDTH-1:0] IDX_ONE  = IDX_WIDTH'(1);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(K - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Number of set bits in one scan chunk.
  function automatic logic [COUNT_WIDTH-1:0] chunk_ones(input logic [BITS_PER_CYCLE-1:0] chunk);
    logic [COUNT_WIDTH-1:0] sum;
    sum = {COUNT_WIDTH{1'b0}};
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      sum = sum + COUNT_WIDTH'(chunk[i]);
    end
    return sum;
  endfunction

  state_t                 state_r, state_s;
  logic [DATA_WIDTH-1:0]  shift_r, shift_s;
  logic [COUNT_WIDTH-1:0] acc_r, acc_s;
  logic [IDX_WIDTH-1:0]   idx_r, idx_s;
  logic                   busy_r, busy_s;
  logic                   done_r, done_s;
  logic [COUNT_WIDTH-1:0] count_r, count_s;

  // Next-state and datapath update for the three-state scan sequence.
  always_comb begin
    state_s = state_r;
    shift_s = shift_r;
    acc_s   = acc_r;
    idx_s   = idx_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    count_s = count_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          // Counting zeros is counting ones of the inverted operand.
          shift_s = count_zeros ? ~data : data;
          acc_s   = {COUNT_WIDTH{1'b0}};
          idx_s   = {IDX_WIDTH{1'b0}};
          busy_s  = 1'b1;
          state_s = SCAN;
        end else begin
          busy_s  = 1'b0;
        end
      end
      SCAN: begin
        acc_s   = acc_r + chunk_ones(shift_r[BITS_PER_CYCLE-1:0]);
        shift_s = shift_r >> BITS_PER_CYCLE;
        idx_s   = idx_r + IDX_ONE;
        if (idx_r == LAST_IDX) begin
          state_s = FINISH;
        end else begin
          state_s = SCAN;
        end
      end
      FINISH: begin
        count_s = acc_r;
        done_s  = 1'b1;
        busy_s  = 1'b0;
        state_s = IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset overrides any pending start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      shift_r <= {DATA_WIDTH{1'b0}};
      acc_r   <= {COUNT_WIDTH{1'b0}};
      idx_r   <= {IDX_WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      count_r <= {COUNT_WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      shift_r <= shift_s;
      acc_r   <= acc_s;
      idx_r   <= idx_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      count_r <= count_s;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign bit_count = count_r;

endmodule

// File: doc/popcount_seq.md
POPCOUNT_SEQ -- requirements
Module: popcount_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of the operand word.
REQ-002 Parameter BITS_PER_CYCLE, default 4: operand bits examined per scan cycle; SHALL be an exact divisor of DATA_WIDTH.
REQ-003 Parameter COUNT_WIDTH, default 5: result width; SHALL satisfy 2**COUNT_WIDTH > DATA_WIDTH.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  request to begin a count; sampled only in IDLE.
REQ-007 count_zeros  input  1  mode select: 0 counts ones, 1 counts zeros; sampled with start.
REQ-008 data  input  DATA_WIDTH  operand; sampled with start.
REQ-009 busy  output  1  high from start acceptance until the result is published.
REQ-010 done  output  1  one-cycle pulse marking a new valid bit_count.
REQ-011 bit_count  output  COUNT_WIDTH  most recent result; held between operations.

Function
REQ-012 The FSM SHALL have states IDLE, SCAN and FINISH.
REQ-013 In IDLE with start=1, the edge SHALL capture data (inverted if count_zeros=1) into a shift register, clear the accumulator and chunk index, set busy=1, and enter SCAN.
REQ-014 Each SCAN edge SHALL add the popcount of the low BITS_PER_CYCLE bits of the shift register to the accumulator, shift the register right by BITS_PER_CYCLE, and increment the chunk index.
REQ-015 SCAN SHALL last exactly K = DATA_WIDTH/BITS_PER_CYCLE edges, then enter FINISH.
REQ-016 The FINISH edge SHALL load bit_count with the accumulator, pulse done=1 for one cycle, clear busy, and return to IDLE.
REQ-017 Latency: start accepted at edge N -> bit_count valid and done=1 after edge N+K+1, independent of data value and mode.
REQ-018 start SHALL be ignored in SCAN and FINISH; the next start can be accepted at edge N+K+2 at the earliest.
REQ-019 data and count_zeros changes after acceptance SHALL NOT affect the running operation.
REQ-020 bit_count SHALL hold its last value while IDLE, SCAN and FINISH until the next FINISH edge; done SHALL be 0 in every cycle except the one following FINISH.
REQ-021 The accumulator SHALL be COUNT_WIDTH bits wide; the all-ones or all-zeros operand SHALL yield exactly DATA_WIDTH with no wrap.
REQ-022 BITS_PER_CYCLE = DATA_WIDTH SHALL give K=1 (latency 2); BITS_PER_CYCLE = 1 SHALL give K = DATA_WIDTH.

Reset
REQ-023 reset=1 at any edge SHALL force IDLE, busy=0, done=0, bit_count=0, accumulator=0, chunk index=0, overriding start.
REQ-024 reset during SCAN or FINISH SHALL abort the operation with no done pulse and bit_count=0.
REQ-025 After reset deasserts, a start in the first non-reset cycle SHALL be accepted.

Verification (DATA_WIDTH=16, BITS_PER_CYCLE=4, K=4)
REQ-026 start, data=16'hF0F1, count_zeros=0 at edge N -> busy=1 after N through N+4; done=1 and bit_count=9 after edge N+5, busy=0.
REQ-027 Same data, count_zeros=1 -> bit_count=7 after edge N+5; data=16'hFFFF ones mode -> 16; data=16'h0000 ones mode -> 0.
REQ-028 Second start and new data=16'h0000 asserted during SCAN of 16'hFFFF -> ignored; result 16, single done pulse.
REQ-029 reset asserted at edge N+2 of an operation -> busy=0, done=0, bit_count=0 after that edge; no done pulse follows.
REQ-030 Back-to-back: start held high continuously with data=16'h000F -> results 4 every K+2=6 cycles, done pulses spaced 6 cycles apart.
REQ-031 Re-run REQ-026 with BITS_PER_CYCLE=1 and 16 -> bit_count=9 after edge N+17 and N+2 respectively.
